rgb_unswap_sync: RTL and testbench

Receive-side inverse of the channel-swap effect. Takes swapped 24-bit pixel video plus syncs and restores canonical channel order, {B,G,R} in [23:16],[15:8],[7:0]. Mode and bypass requests are shadowed and applied only at a frame boundary, so a mode change never tears mid-frame. Sits in the pixel-clock video_fx chain, after any stage that applied the forward swap.

---
 rtl/rgb_fx_pkg.sv | 12 +
 rtl/rgb_unswap_core.sv | 36 +++
 rtl/rgb_unswap_sync.sv | 124 ++++++++++++
 tb/tb_rgb_unswap_sync.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fx_pkg.sv
// Constants shared by the forward channel-swap block and its receive-side inverse,
// so that both ends decode the mode field from the same definitions.
package rgb_fx_pkg;

  localparam int CH_W_DEFAULT = 8;

  localparam logic [1:0] MODE_BGR_SWAP = 2'b00;
  localparam logic [1:0] MODE_GBR      = 2'b01;
  localparam logic [1:0] MODE_BRG      = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

endpackage

// File: rtl/rgb_unswap_core.sv
// Combinational channel un-permutation: undoes the forward swap selected by mode,
// or passes the pixel through untouched when bypass is set.
module rgb_unswap_core
  import rgb_fx_pkg::*;
#(
  parameter int CH_W = CH_W_DEFAULT
) (
  input  logic [3*CH_W-1:0] data,
  input  logic [1:0]        mode,
  input  logic              bypass,
  output logic [3*CH_W-1:0] restored
);

  logic [CH_W-1:0] hi;
  logic [CH_W-1:0] mid;
  logic [CH_W-1:0] lo;

  assign hi  = data[3*CH_W-1:2*CH_W];
  assign mid = data[2*CH_W-1:CH_W];
  assign lo  = data[CH_W-1:0];

  // The reserved mode decodes exactly like the outer-channel swap.
  always_comb begin
    restored = {lo, mid, hi};
    if (bypass) begin
      restored = data;
    end else begin
      case (mode)
        MODE_GBR: restored = {mid, hi, lo};
        MODE_BRG: restored = {hi, lo, mid};
        default:  restored = {lo, mid, hi};
      endcase
    end
  end

endmodule

// File: rtl/rgb_unswap_sync.sv
// Receive-side inverse of the channel swap with a fixed 2-cycle pipeline; mode and
// bypass requests are shadowed and only take effect at a vsync leading edge.
module rgb_unswap_sync
  import rgb_fx_pkg::*;
#(
  parameter int   CH_W      = CH_W_DEFAULT,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic                PixelClk,
  input  logic                rst,
  input  logic [3*CH_W-1:0]   vid_pData_in,
  input  logic                vid_pVDE_in,
  input  logic                vid_pHSync_in,
  input  logic                vid_pVSync_in,
  input  logic [1:0]          mode,
  input  logic                bypass,
  output logic [3*CH_W-1:0]   vid_pData_out,
  output logic                vid_pVDE_out,
  output logic                vid_pHSync_out,
  output logic                vid_pVSync_out,
  output logic [1:0]          mode_active,
  output logic                mode_pending
);

  localparam int PIX_W = 3 * CH_W;

  logic             vs_hist;
  logic [1:0]       active_mode;
  logic             active_bypass;
  logic             pending;

  logic             boundary;
  logic [1:0]       eff_mode;
  logic             eff_bypass;
  logic             pending_next;

  logic [PIX_W-1:0] data_p1;
  logic [1:0]       mode_p1;
  logic             bypass_p1;
  logic             de_p1;
  logic             hs_p1;
  logic             vs_p1;

  logic [PIX_W-1:0] restored_p1;

  logic [PIX_W-1:0] data_p2;
  logic             de_p2;
  logic             hs_p2;
  logic             vs_p2;

  // A boundary needs a genuine inactive-to-active vsync transition.
  assign boundary   = (vid_pVSync_in == VSYNC_POL) && (vs_hist != VSYNC_POL);
  assign eff_mode   = boundary ? mode   : active_mode;
  assign eff_bypass = boundary ? bypass : active_bypass;

  // Compare against the settings that will be active after this edge, so the
  // flag drops right after a boundary that latches the current request.
  assign pending_next = (mode != eff_mode) || (bypass != eff_bypass);

  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      vs_hist       <= ~VSYNC_POL;
      active_mode   <= MODE_BGR_SWAP;
      active_bypass <= 1'b0;
      pending       <= 1'b0;
    end else begin
      vs_hist       <= vid_pVSync_in;
      active_mode   <= eff_mode;
      active_bypass <= eff_bypass;
      pending       <= pending_next;
    end
  end

  // Stage 1: capture pixel, syncs and the settings that apply to this pixel.
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      data_p1   <= '0;
      mode_p1   <= MODE_BGR_SWAP;
      bypass_p1 <= 1'b0;
      de_p1     <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
    end else begin
      data_p1   <= vid_pData_in;
      mode_p1   <= eff_mode;
      bypass_p1 <= eff_bypass;
      de_p1     <= vid_pVDE_in;
      hs_p1     <= vid_pHSync_in;
      vs_p1     <= vid_pVSync_in;
    end
  end

  rgb_unswap_core #(
    .CH_W (CH_W)
  ) u_core (
    .data     (data_p1),
    .mode     (mode_p1),
    .bypass   (bypass_p1),
    .restored (restored_p1)
  );

  // Stage 2: register the restored pixel alongside the stage-1 syncs.
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      data_p2 <= '0;
      de_p2   <= 1'b0;
      hs_p2   <= 1'b0;
      vs_p2   <= 1'b0;
    end else begin
      data_p2 <= restored_p1;
      de_p2   <= de_p1;
      hs_p2   <= hs_p1;
      vs_p2   <= vs_p1;
    end
  end

  assign vid_pData_out  = data_p2;
  assign vid_pVDE_out   = de_p2;
  assign vid_pHSync_out = hs_p2;
  assign vid_pVSync_out = vs_p2;
  assign mode_active    = active_mode;
  assign mode_pending   = pending;

endmodule

// File: tb/tb_rgb_unswap_sync.sv
// Directed and randomized stimulus for rgb_unswap_sync, checked against a
// frame-level reference model of the channel restore and setting latch.
module tb_rgb_unswap_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        de = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        bypass = 1'b0;
  logic [23:0] dout;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic [1:0]  mode_act;
  logic        mode_pend;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [23:0] data;
    logic        de;
    logic        hs;
    logic        vs;
  } pix_t;

  pix_t        q[$];
  logic [1:0]  m_act = 2'b00;
  logic        m_byp = 1'b0;
  logic        m_prev_vs = 1'b0;
  logic        m_pend = 1'b0;

  rgb_unswap_sync #(
    .CH_W      (8),
    .VSYNC_POL (1'b1)
  ) dut (
    .PixelClk       (clk),
    .rst            (rst),
    .vid_pData_in   (din),
    .vid_pVDE_in    (de),
    .vid_pHSync_in  (hs),
    .vid_pVSync_in  (vs),
    .mode           (mode),
    .bypass         (bypass),
    .vid_pData_out  (dout),
    .vid_pVDE_out   (de_o),
    .vid_pHSync_out (hs_o),
    .vid_pVSync_out (vs_o),
    .mode_active    (mode_act),
    .mode_pending   (mode_pend)
  );

  always #5 clk = ~clk;

  // Restore table: input bytes H=[23:16], M=[15:8], L=[7:0].
  function automatic logic [23:0] restore(input logic [23:0] d, input logic [1:0] m,
                                          input logic b);
    logic [7:0] h, mm, l;
    h = d[23:16];
    mm = d[15:8];
    l = d[7:0];
    if (b) return d;
    if (m == 2'b01) return {mm, h, l};
    if (m == 2'b10) return {h, l, mm};
    return {l, mm, h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_act = 2'b00;
    m_byp = 1'b0;
    m_prev_vs = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic check_outputs();
    pix_t e;
    e = '0;
    if (q.size() >= 2) e = q[q.size()-2];
    chk("data", {8'h0, dout}, {8'h0, e.data});
    chk("de", {31'h0, de_o}, {31'h0, e.de});
    chk("hsync", {31'h0, hs_o}, {31'h0, e.hs});
    chk("vsync", {31'h0, vs_o}, {31'h0, e.vs});
    chk("mode_active", {30'h0, mode_act}, {30'h0, m_act});
    chk("mode_pending", {31'h0, mode_pend}, {31'h0, m_pend});
  endtask

  task automatic tick();
    pix_t p;
    @(posedge clk);
    if (!rst) begin
      if (vs && !m_prev_vs) begin
        m_act = mode;
        m_byp = bypass;
      end
      m_prev_vs = vs;
      p.data = restore(din, m_act, m_byp);
      p.de = de;
      p.hs = hs;
      p.vs = vs;
      q.push_back(p);
      if (q.size() > 2) void'(q.pop_front());
      m_pend = (mode != m_act) || (bypass != m_byp);
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input logic [23:0] pat, input logic vsv);
    for (int i = 0; i < n; i++) begin
      din = pat;
      de = 1'b1;
      hs = (i == 0);
      vs = vsv;
      tick();
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    tick();
    tick();
    rst = 1'b0;

    // Mode 00 streaming across a vsync pulse
    mode = 2'b00;
    run(4, 24'hCCBBAA, 1'b0);
    run(2, 24'hCCBBAA, 1'b1);
    run(6, 24'hCCBBAA, 1'b0);
    chk("mode00_direct", {8'h0, dout}, 32'h00AABBCC);

    // Mid-frame request change to 01: pending, mapping unchanged
    run(5, 24'hCCBBAA, 1'b0);
    mode = 2'b01;
    run(6, 24'hCCBBAA, 1'b0);
    chk("pending_mid_frame", {31'h0, mode_pend}, 32'h1);
    chk("mapping_held", {8'h0, dout}, 32'h00AABBCC);
    run(2, 24'hBBAACC, 1'b1);
    chk("active_01", {30'h0, mode_act}, 32'h1);
    chk("pending_cleared", {31'h0, mode_pend}, 32'h0);
    run(6, 24'hBBAACC, 1'b0);
    chk("roundtrip_01", {8'h0, dout}, 32'h00AABBCC);

    // Mode 10 round trip
    mode = 2'b10;
    run(3, 24'hBBAACC, 1'b0);
    run(2, 24'hAACCBB, 1'b1);
    run(6, 24'hAACCBB, 1'b0);
    chk("roundtrip_10", {8'h0, dout}, 32'h00AABBCC);

    // Bypass latched, then vsync held active for three lines while bypass toggles
    bypass = 1'b1;
    run(3, 24'h123456, 1'b0);
    for (int i = 0; i < 30; i++) begin
      din = 24'h123456;
      de = (i % 10) < 8;
      hs = (i % 10) == 9;
      vs = 1'b1;
      if (i > 0 && (i % 7) == 0) bypass = ~bypass;
      tick();
    end
    bypass = 1'b1;
    run(4, 24'h123456, 1'b0);
    chk("bypass_held", {8'h0, dout}, 32'h00123456);

    // Asynchronous reset with the pipeline full
    bypass = 1'b0;
    mode = 2'b01;
    run(3, 24'h5A5A00, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("rst_mode_active", {30'h0, mode_act}, 32'h0);
    tick();
    rst = 1'b0;
    mode = 2'b00;
    run(4, 24'hCCBBAA, 1'b0);

    // Reserved mode behaves like 00
    mode = 2'b11;
    run(2, 24'hCCBBAA, 1'b1);
    run(4, 24'hCCBBAA, 1'b0);
    chk("mode11", {8'h0, dout}, 32'h00AABBCC);

    // Randomized frames with occasional request changes, including on boundaries
    for (int f = 0; f < 6; f++) begin
      for (int l = 0; l < 4; l++) begin
        for (int px = 0; px < 10; px++) begin
          din = 24'($urandom);
          de = px < 8;
          hs = px == 9;
          vs = (l == 0) && (px < 3);
          if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) bypass = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
